// File: rtl/mem_1rw_bank_resp_if.sv
// Bundled per-bank request/response, error-injection and collision-count signals
// for mem_1rw_bank_resp.
interface mem_1rw_bank_resp_if #(
    parameter int NUMPBNK = 11,
    parameter int WIDTH   = 32,
    parameter int BITVROW = 10,
    parameter int BITPBNK = 4,
    parameter int BITPADR = 15
) ();
    logic [NUMPBNK-1:0]                   t1_readA;
    logic [NUMPBNK-1:0]                   t1_writeA;
    logic [NUMPBNK*BITVROW-1:0]           t1_addrA;
    logic [NUMPBNK*WIDTH-1:0]             t1_dinA;
    logic [NUMPBNK*WIDTH-1:0]             t1_doutA;
    logic [NUMPBNK-1:0]                   t1_fwrdA;
    logic [NUMPBNK-1:0]                   t1_serrA;
    logic [NUMPBNK-1:0]                   t1_derrA;
    logic [NUMPBNK*(BITPADR-BITPBNK)-1:0] t1_padrA;
    logic                                 inj_vld;
    logic [BITPBNK-1:0]                   inj_bank;
    logic [BITVROW-1:0]                   inj_row;
    logic                                 inj_dbl;
    logic [15:0]                          coll_cnt;

    modport master (
        output t1_readA, t1_writeA, t1_addrA, t1_dinA, inj_vld, inj_bank, inj_row, inj_dbl,
        input  t1_doutA, t1_fwrdA, t1_serrA, t1_derrA, t1_padrA, coll_cnt
    );

    modport slave (
        input  t1_readA, t1_writeA, t1_addrA, t1_dinA, inj_vld, inj_bank, inj_row, inj_dbl,
        output t1_doutA, t1_fwrdA, t1_serrA, t1_derrA, t1_padrA, coll_cnt
    );
endinterface

// File: rtl/mem_1rw_bank_resp.sv
// Bank of independent 1RW arrays with a fixed-latency read pipeline, forward/error flags,
// per-row error injection and a saturating read/write collision counter.
module mem_1rw_bank_resp #(
    parameter int NUMPBNK    = 11,
    parameter int WIDTH      = 32,
    parameter int NUMVROW    = 1024,
    parameter int BITVROW    = 10,
    parameter int BITPBNK    = 4,
    parameter int BITPADR    = 15,
    parameter int DRAM_DELAY = 1
) (
    input  logic                clk,
    input  logic                rst,
    mem_1rw_bank_resp_if.slave  bus
);
    localparam int PW = BITPADR - BITPBNK;
    localparam int D  = DRAM_DELAY;

    logic [WIDTH-1:0]   mem [NUMPBNK][NUMVROW];
    logic [BITVROW-1:0] row_a [NUMPBNK];

    logic [NUMVROW-1:0] sflag_q [NUMPBNK];
    logic [NUMVROW-1:0] sflag_d [NUMPBNK];
    logic [NUMVROW-1:0] dflag_q [NUMPBNK];
    logic [NUMVROW-1:0] dflag_d [NUMPBNK];
    logic [NUMPBNK-1:0] lw_vld_q, lw_vld_d;
    logic [BITVROW-1:0] lw_row_q [NUMPBNK];
    logic [BITVROW-1:0] lw_row_d [NUMPBNK];
    logic [15:0]        coll_q, coll_d;
    logic [16:0]        coll_sum;

    logic [D-1:0]       vld_q  [NUMPBNK];
    logic [D-1:0]       vld_d  [NUMPBNK];
    logic [D-1:0]       fwrd_q [NUMPBNK];
    logic [D-1:0]       fwrd_d [NUMPBNK];
    logic [D-1:0]       serr_q [NUMPBNK];
    logic [D-1:0]       serr_d [NUMPBNK];
    logic [D-1:0]       derr_q [NUMPBNK];
    logic [D-1:0]       derr_d [NUMPBNK];
    logic [WIDTH-1:0]   dat_q  [NUMPBNK][D];
    logic [WIDTH-1:0]   dat_d  [NUMPBNK][D];
    logic [PW-1:0]      padr_q [NUMPBNK][D];
    logic [PW-1:0]      padr_d [NUMPBNK][D];

    always_comb begin
        for (int b = 0; b < NUMPBNK; b++) begin
            row_a[b] = bus.t1_addrA[b*BITVROW +: BITVROW];
        end
    end

    // Array content is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUMPBNK; b++) begin
            if (bus.t1_writeA[b]) begin
                mem[b][row_a[b]] <= bus.t1_dinA[b*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        coll_sum = {1'b0, coll_q};
        for (int b = 0; b < NUMPBNK; b++) begin
            sflag_d[b]  = sflag_q[b];
            dflag_d[b]  = dflag_q[b];
            lw_vld_d[b] = bus.t1_writeA[b];
            lw_row_d[b] = row_a[b];
            coll_sum    = coll_sum + 17'(bus.t1_readA[b] & bus.t1_writeA[b]);

            // Injection first so a same-cycle write to the row clears it again.
            if (bus.inj_vld && bus.inj_bank == BITPBNK'(b)) begin
                if (bus.inj_dbl) dflag_d[b][bus.inj_row] = 1'b1;
                else             sflag_d[b][bus.inj_row] = 1'b1;
            end
            if (bus.t1_writeA[b]) begin
                sflag_d[b][row_a[b]] = 1'b0;
                dflag_d[b][row_a[b]] = 1'b0;
            end

            for (int s = D - 1; s > 0; s--) begin
                vld_d[b][s]  = vld_q[b][s-1];
                fwrd_d[b][s] = fwrd_q[b][s-1];
                serr_d[b][s] = serr_q[b][s-1];
                derr_d[b][s] = derr_q[b][s-1];
                dat_d[b][s]  = dat_q[b][s-1];
                padr_d[b][s] = padr_q[b][s-1];
            end
            // A read colliding with a write on the same bank is dropped.
            vld_d[b][0]  = bus.t1_readA[b] & ~bus.t1_writeA[b];
            fwrd_d[b][0] = lw_vld_q[b] && (lw_row_q[b] == row_a[b]);
            derr_d[b][0] = dflag_q[b][row_a[b]];
            serr_d[b][0] = sflag_q[b][row_a[b]] & ~dflag_q[b][row_a[b]];
            dat_d[b][0]  = mem[b][row_a[b]] ^ (dflag_q[b][row_a[b]] ? WIDTH'(2'b11) : '0);
            padr_d[b][0] = PW'(row_a[b]);
        end
        coll_d = coll_sum[16] ? 16'hFFFF : coll_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coll_q   <= '0;
            lw_vld_q <= '0;
            for (int b = 0; b < NUMPBNK; b++) begin
                sflag_q[b]  <= '0;
                dflag_q[b]  <= '0;
                lw_row_q[b] <= '0;
                vld_q[b]    <= '0;
                fwrd_q[b]   <= '0;
                serr_q[b]   <= '0;
                derr_q[b]   <= '0;
                for (int s = 0; s < D; s++) begin
                    dat_q[b][s]  <= '0;
                    padr_q[b][s] <= '0;
                end
            end
        end else begin
            coll_q   <= coll_d;
            lw_vld_q <= lw_vld_d;
            for (int b = 0; b < NUMPBNK; b++) begin
                sflag_q[b]  <= sflag_d[b];
                dflag_q[b]  <= dflag_d[b];
                lw_row_q[b] <= lw_row_d[b];
                vld_q[b]    <= vld_d[b];
                fwrd_q[b]   <= fwrd_d[b];
                serr_q[b]   <= serr_d[b];
                derr_q[b]   <= derr_d[b];
                for (int s = 0; s < D; s++) begin
                    dat_q[b][s]  <= dat_d[b][s];
                    padr_q[b][s] <= padr_d[b][s];
                end
            end
        end
    end

    // Outputs are driven only in the cycle a read returns.
    always_comb begin
        bus.t1_doutA = '0;
        bus.t1_fwrdA = '0;
        bus.t1_serrA = '0;
        bus.t1_derrA = '0;
        bus.t1_padrA = '0;
        for (int b = 0; b < NUMPBNK; b++) begin
            if (vld_q[b][D-1]) begin
                bus.t1_doutA[b*WIDTH +: WIDTH] = dat_q[b][D-1];
                bus.t1_fwrdA[b]                = fwrd_q[b][D-1];
                bus.t1_serrA[b]                = serr_q[b][D-1];
                bus.t1_derrA[b]                = derr_q[b][D-1];
                bus.t1_padrA[b*PW +: PW]       = padr_q[b][D-1];
            end
        end
    end

    assign bus.coll_cnt = coll_q;
endmodule

// File: tb/tb_mem_1rw_bank_resp.sv
// Directed bench for mem_1rw_bank_resp: latency, forwarding, error flags, collisions, reset flush.
module tb_mem_1rw_bank_resp;
    localparam int NB = 11;
    localparam int W  = 32;
    localparam int NR = 1024;
    localparam int BR = 10;
    localparam int BB = 4;
    localparam int BP = 15;
    localparam int DD = 2;
    localparam int PW = BP - BB;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_1rw_bank_resp_if #(
        .NUMPBNK(NB), .WIDTH(W), .BITVROW(BR), .BITPBNK(BB), .BITPADR(BP)
    ) bus ();

    mem_1rw_bank_resp #(
        .NUMPBNK(NB), .WIDTH(W), .NUMVROW(NR), .BITVROW(BR), .BITPBNK(BB), .BITPADR(BP),
        .DRAM_DELAY(DD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.t1_readA  = '0;
        bus.t1_writeA = '0;
        bus.t1_addrA  = '0;
        bus.t1_dinA   = '0;
        bus.inj_vld   = 1'b0;
        bus.inj_bank  = '0;
        bus.inj_row   = '0;
        bus.inj_dbl   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input int b, input int row);
        bus.t1_readA[b]          = 1'b1;
        bus.t1_addrA[b*BR +: BR] = BR'(row);
    endtask

    task automatic wr(input int b, input int row, input logic [W-1:0] d);
        bus.t1_writeA[b]         = 1'b1;
        bus.t1_addrA[b*BR +: BR] = BR'(row);
        bus.t1_dinA[b*W +: W]    = d;
    endtask

    task automatic inj(input int b, input int row, input logic dbl);
        bus.inj_vld  = 1'b1;
        bus.inj_bank = BB'(b);
        bus.inj_row  = BR'(row);
        bus.inj_dbl  = dbl;
    endtask

    function automatic logic [W-1:0] dout(input int b);
        return bus.t1_doutA[b*W +: W];
    endfunction

    function automatic logic [PW-1:0] padr(input int b);
        return bus.t1_padrA[b*PW +: PW];
    endfunction

    task automatic all_zero(input string tag);
        check({tag, "_dout"}, 64'(|bus.t1_doutA), 64'd0);
        check({tag, "_flags"},
              64'(|{bus.t1_fwrdA, bus.t1_serrA, bus.t1_derrA, bus.t1_padrA}), 64'd0);
        check({tag, "_coll"}, 64'(bus.coll_cnt), 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        repeat (2) tick();
        all_zero("reset");
        rst = 1'b1;
        tick();

        // Write, idle, read: data returns exactly DD cycles after the read, once.
        wr(3, 5, 32'hDEADBEEF);
        tick();
        tick();
        rd(3, 5);
        tick();
        check("lat_early", 64'(dout(3)), 64'd0);
        tick();
        check("lat_data", 64'(dout(3)), 64'hDEADBEEF);
        check("lat_fwrd", 64'(bus.t1_fwrdA[3]), 64'd0);
        check("lat_padr", 64'(padr(3)), 64'd5);
        check("lat_errs", 64'({bus.t1_serrA[3], bus.t1_derrA[3]}), 64'd0);
        tick();
        check("lat_after", 64'(dout(3)), 64'd0);
        check("lat_padr0", 64'(padr(3)), 64'd0);

        // Forward flag: set for read of the row written the previous cycle only.
        wr(0, 7, 32'h1);
        tick();
        rd(0, 7);
        tick();
        tick();
        check("fwd_data", 64'(dout(0)), 64'h1);
        check("fwd_flag", 64'(bus.t1_fwrdA[0]), 64'd1);
        wr(0, 8, 32'h2);
        tick();
        rd(0, 7);
        tick();
        tick();
        check("nofwd_data", 64'(dout(0)), 64'h1);
        check("nofwd_flag", 64'(bus.t1_fwrdA[0]), 64'd0);

        // Double-error injection flips bits [1:0]; rewriting clears it.
        wr(2, 9, 32'hF0);
        tick();
        inj(2, 9, 1'b1);
        tick();
        rd(2, 9);
        tick();
        tick();
        check("dbl_data", 64'(dout(2)), 64'hF3);
        check("dbl_derr", 64'(bus.t1_derrA[2]), 64'd1);
        check("dbl_serr", 64'(bus.t1_serrA[2]), 64'd0);
        wr(2, 9, 32'hF0);
        tick();
        tick();
        rd(2, 9);
        tick();
        tick();
        check("clr_data", 64'(dout(2)), 64'hF0);
        check("clr_derr", 64'(bus.t1_derrA[2]), 64'd0);

        // Single-error injection: data intact, serr only.
        wr(4, 3, 32'h55);
        tick();
        inj(4, 3, 1'b0);
        tick();
        rd(4, 3);
        tick();
        tick();
        check("sgl_data", 64'(dout(4)), 64'h55);
        check("sgl_flags", 64'({bus.t1_serrA[4], bus.t1_derrA[4]}), 64'b10);

        // Injection and write to the same row in one cycle: write wins.
        wr(5, 1, 32'hA);
        inj(5, 1, 1'b1);
        tick();
        tick();
        rd(5, 1);
        tick();
        tick();
        check("ww_data", 64'(dout(5)), 64'hA);
        check("ww_flags", 64'({bus.t1_serrA[5], bus.t1_derrA[5]}), 64'd0);

        // Same-bank collisions: write happens, read is dropped.
        for (int i = 0; i < 3; i++) begin
            wr(1, 2, 32'h11 * (i + 1));
            bus.t1_readA[1] = 1'b1;
            tick();
            check("coll_noret", 64'(dout(1)), 64'd0);
        end
        tick();
        check("coll_noret_late", 64'(dout(1)), 64'd0);
        check("coll_cnt3", 64'(bus.coll_cnt), 64'd3);
        rd(1, 2);
        tick();
        tick();
        check("coll_wr_vis", 64'(dout(1)), 64'h33);

        // All banks colliding at once count one per bank, then saturate.
        for (int b = 0; b < NB; b++) wr(b, 0, 32'(b));
        bus.t1_readA = '1;
        tick();
        check("coll_multi", 64'(bus.coll_cnt), 64'd14);
        for (int n = 0; n < 5957; n++) begin
            for (int b = 0; b < NB; b++) wr(b, 0, 32'(b));
            bus.t1_readA = '1;
            tick();
        end
        check("coll_sat", 64'(bus.coll_cnt), 64'hFFFF);
        wr(1, 0, 32'h0);
        bus.t1_readA[1] = 1'b1;
        tick();
        check("coll_sat_hold", 64'(bus.coll_cnt), 64'hFFFF);

        // Reset with a read in flight: the read never returns, flags and count cleared.
        wr(6, 4, 32'h77);
        tick();
        inj(6, 4, 1'b1);
        tick();
        rd(3, 5);
        tick();
        rst = 1'b0;
        #1;
        all_zero("rst_async");
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_dout", 64'(dout(3)), 64'd0);
            check("flush_padr", 64'(padr(3)), 64'd0);
        end
        check("flush_coll", 64'(bus.coll_cnt), 64'd0);
        rd(6, 4);
        tick();
        tick();
        check("flush_data", 64'(dout(6)), 64'h77);
        check("flush_derr", 64'(bus.t1_derrA[6]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
